random_xy_gen: RTL and testbench



---
 rtl/random_xy_gen.sv | 169 ++++++++++++++++
 tb/tb_random_xy_gen.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/random_xy_gen.sv
// Random grid-coordinate generator: XNOR LFSR feeding a rejection-sampling FSM
// that returns a uniform in-range (x,y), optionally avoiding one forbidden cell.
module random_xy_gen #(
  parameter int                LFSR_W    = 32,
  parameter logic [LFSR_W-1:0] TAPS      = 32'h8020_0003,
  parameter int                SIZE_X    = 40,
  parameter int                SIZE_Y    = 20,
  parameter int                COORD_W   = 6,
  parameter int                MAX_TRIES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic               load,
  input  logic [LFSR_W-1:0]  seed,
  input  logic               req,
  input  logic               avoid_en,
  input  logic [COORD_W-1:0] avoid_x,
  input  logic [COORD_W-1:0] avoid_y,
  output logic               busy,
  output logic               valid,
  output logic               exhausted,
  output logic [COORD_W-1:0] random_x,
  output logic [COORD_W-1:0] random_y,
  output logic [2:0]         dbg_state,
  output logic [LFSR_W-1:0]  dbg_lfsr
);

  // Handshake: req is sampled only in IDLE; busy is high from the edge that
  // accepts req until the DONE cycle ends; valid pulses for exactly one
  // enabled cycle and qualifies random_x/random_y/exhausted, which then hold.

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAW_X = 3'd1,
    DRAW_Y = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  state_t             state;
  logic [LFSR_W-1:0]  lfsr;
  logic [LFSR_W-1:0]  lfsr_next;
  logic               fb;
  logic [TRY_W-1:0]   try_cnt;
  logic [TRY_W-1:0]   try_inc;
  logic               try_hit;
  logic [COORD_W-1:0] cx;
  logic [COORD_W-1:0] cy;
  logic [COORD_W-1:0] lat_x;
  logic [COORD_W-1:0] lat_y;
  logic [COORD_W-1:0] fallback_x;
  logic               cx_ok;
  logic               cy_ok;
  logic               avoid_hit;
  logic               reject;
  logic               fall;

  assign fb        = ~^(lfsr & TAPS);
  assign lfsr_next = {lfsr[LFSR_W-2:0], fb};

  assign cx = lfsr[COORD_W-1:0];
  assign cy = lfsr[2*COORD_W-1:COORD_W];

  // One extra bit so a grid dimension of exactly 2^COORD_W still compares.
  assign cx_ok = ({1'b0, cx} < (COORD_W+1)'(SIZE_X));
  assign cy_ok = ({1'b0, cy} < (COORD_W+1)'(SIZE_Y));

  // Latched pair is always in range, so an out-of-grid forbidden cell never hits.
  assign avoid_hit = avoid_en && (avoid_x == lat_x) && (avoid_y == lat_y);

  assign reject = ((state == DRAW_X) && !cx_ok) ||
                  ((state == DRAW_Y) && !cy_ok) ||
                  ((state == CHECK)  && avoid_hit);

  assign try_inc = try_cnt + TRY_W'(1);
  assign try_hit = (try_inc == TRY_W'(MAX_TRIES));
  assign fall    = reject && try_hit;

  // (0,0) unless that is the forbidden cell; SIZE_X >= 2 keeps (1,0) legal.
  assign fallback_x = (avoid_en && (avoid_x == '0)) ? COORD_W'(1) : '0;

  assign dbg_state = state;
  assign dbg_lfsr  = lfsr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr      <= '0;
      state     <= IDLE;
      try_cnt   <= '0;
      lat_x     <= '0;
      lat_y     <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      exhausted <= 1'b0;
      random_x  <= '0;
      random_y  <= '0;
    end else if (clk_en) begin
      if (load) begin
        // An all-ones state would lock an XNOR LFSR, so substitute zero.
        lfsr    <= (&seed) ? '0 : seed;
        state   <= IDLE;
        try_cnt <= '0;
        busy    <= 1'b0;
        valid   <= 1'b0;
      end else begin
        lfsr  <= lfsr_next;
        valid <= 1'b0;
        if (fall) begin
          state     <= DONE;
          try_cnt   <= try_inc;
          valid     <= 1'b1;
          exhausted <= 1'b1;
          random_x  <= fallback_x;
          random_y  <= '0;
        end else begin
          case (state)
            IDLE: begin
              if (req) begin
                state   <= DRAW_X;
                try_cnt <= '0;
                busy    <= 1'b1;
              end
            end
            DRAW_X: begin
              if (cx_ok) begin
                lat_x <= cx;
                state <= DRAW_Y;
              end else begin
                try_cnt <= try_inc;
              end
            end
            DRAW_Y: begin
              if (cy_ok) begin
                lat_y <= cy;
                state <= CHECK;
              end else begin
                try_cnt <= try_inc;
              end
            end
            CHECK: begin
              if (avoid_hit) begin
                try_cnt <= try_inc;
                state   <= DRAW_X;
              end else begin
                state     <= DONE;
                valid     <= 1'b1;
                exhausted <= 1'b0;
                random_x  <= lat_x;
                random_y  <= lat_y;
              end
            end
            DONE: begin
              state <= IDLE;
              busy  <= 1'b0;
            end
            default: begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_random_xy_gen.sv
// Bench for random_xy_gen: four parameterisations share one stimulus stream and
// are checked against a sequential rejection-sampling reference.
module tb_random_xy_gen;

  localparam logic [31:0] TAPS = 32'h8020_0003;
  localparam logic [2:0] S_IDLE = 3'd0, S_DRAW_Y = 3'd2, S_CHECK = 3'd3;

  // Instance k: 0 default, 1 range (MAX_TRIES 64), 2 exclusion 2x1, 3 exhaustion.
  int sx_t[4] = '{40, 40, 2, 2};
  int sy_t[4] = '{20, 20, 1, 1};
  int mt_t[4] = '{16, 64, 16, 1};

  logic        clk = 1'b0;
  logic        reset, clk_en, load, req, avoid_en;
  logic [31:0] seed;
  logic [5:0]  avoid_x, avoid_y;

  logic        busy_w[4], valid_w[4], exh_w[4];
  logic [5:0]  rx_w[4], ry_w[4];
  logic [2:0]  st_w[4];
  logic [31:0] lf_w[4];

  int chk_cnt = 0;
  int pass_cnt = 0;
  logic [31:0] m_lfsr;

  always #5 clk = ~clk;

  random_xy_gen #(.SIZE_X(40), .SIZE_Y(20), .MAX_TRIES(16)) dut0 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .load(load), .seed(seed), .req(req),
    .avoid_en(avoid_en), .avoid_x(avoid_x), .avoid_y(avoid_y), .busy(busy_w[0]),
    .valid(valid_w[0]), .exhausted(exh_w[0]), .random_x(rx_w[0]), .random_y(ry_w[0]),
    .dbg_state(st_w[0]), .dbg_lfsr(lf_w[0]));
  random_xy_gen #(.SIZE_X(40), .SIZE_Y(20), .MAX_TRIES(64)) dut1 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .load(load), .seed(seed), .req(req),
    .avoid_en(avoid_en), .avoid_x(avoid_x), .avoid_y(avoid_y), .busy(busy_w[1]),
    .valid(valid_w[1]), .exhausted(exh_w[1]), .random_x(rx_w[1]), .random_y(ry_w[1]),
    .dbg_state(st_w[1]), .dbg_lfsr(lf_w[1]));
  random_xy_gen #(.SIZE_X(2), .SIZE_Y(1), .MAX_TRIES(16)) dut2 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .load(load), .seed(seed), .req(req),
    .avoid_en(avoid_en), .avoid_x(avoid_x), .avoid_y(avoid_y), .busy(busy_w[2]),
    .valid(valid_w[2]), .exhausted(exh_w[2]), .random_x(rx_w[2]), .random_y(ry_w[2]),
    .dbg_state(st_w[2]), .dbg_lfsr(lf_w[2]));
  random_xy_gen #(.SIZE_X(2), .SIZE_Y(1), .MAX_TRIES(1)) dut3 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .load(load), .seed(seed), .req(req),
    .avoid_en(avoid_en), .avoid_x(avoid_x), .avoid_y(avoid_y), .busy(busy_w[3]),
    .valid(valid_w[3]), .exhausted(exh_w[3]), .random_x(rx_w[3]), .random_y(ry_w[3]),
    .dbg_state(st_w[3]), .dbg_lfsr(lf_w[3]));

  function automatic logic [31:0] step(input logic [31:0] v);
    logic par;
    par = 1'b0;
    for (int i = 0; i < 32; i++) if (TAPS[i]) par = par ^ v[i];
    return {v[30:0], ~par};
  endfunction

  always @(posedge clk) begin
    if (!reset) m_lfsr <= '0;
    else if (clk_en) m_lfsr <= load ? ((seed == 32'hFFFF_FFFF) ? 32'h0 : seed) : step(m_lfsr);
  end

  // Reference: from the LFSR value at the accepting edge, consume one value per
  // edge: draw x, draw y, then screen the forbidden cell; every rejection costs
  // one try, and running out of tries yields the fixed fallback cell.
  function automatic void predict(input logic [31:0] l0, input int k, output int px,
                                  output int py, output bit pexh, output int ed);
    logic [31:0] v;
    int tries, ph, lx, ly;
    bit fin, rej;
    v = step(l0); tries = 0; ph = 0; ed = 0; fin = 0; pexh = 0;
    px = 0; py = 0; lx = 0; ly = 0;
    while (!fin) begin
      ed++; rej = 0;
      if (ph == 0) begin
        if (int'(v[5:0]) < sx_t[k]) begin lx = int'(v[5:0]); ph = 1; end else rej = 1;
      end else if (ph == 1) begin
        if (int'(v[11:6]) < sy_t[k]) begin ly = int'(v[11:6]); ph = 2; end else rej = 1;
      end else begin
        if (avoid_en && int'(avoid_x) == lx && int'(avoid_y) == ly) begin rej = 1; ph = 0; end
        else begin px = lx; py = ly; fin = 1; end
      end
      if (rej) begin
        tries++;
        if (tries == mt_t[k]) begin
          pexh = 1; px = (avoid_en && avoid_x == 6'd0) ? 1 : 0; py = 0; fin = 1;
        end
      end
      v = step(v);
    end
  endfunction

  task automatic load_seed(input logic [31:0] s);
    load = 1'b1; seed = s;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Entered at the negedge right after the accepting edge.
  task automatic wait_valid(input int k, input int ed, input int ex, input int ey,
                            input bit eexh, input string tag);
    int c;
    c = 0;
    chk_cnt++; if (busy_w[k] !== 1'b1) $display("FAIL %s busy: got %b exp 1", tag, busy_w[k]); else pass_cnt++;
    while (valid_w[k] !== 1'b1 && c < 300) begin @(negedge clk); c++; end
    chk_cnt++; if (c != ed) $display("FAIL %s latency: got %0d exp %0d", tag, c, ed); else pass_cnt++;
    chk_cnt++; if (rx_w[k] !== 6'(ex)) $display("FAIL %s x: got %0d exp %0d", tag, rx_w[k], ex); else pass_cnt++;
    chk_cnt++; if (ry_w[k] !== 6'(ey)) $display("FAIL %s y: got %0d exp %0d", tag, ry_w[k], ey); else pass_cnt++;
    chk_cnt++; if (exh_w[k] !== eexh) $display("FAIL %s exhausted: got %b exp %b", tag, exh_w[k], eexh); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (valid_w[k] !== 1'b0) $display("FAIL %s valid_width: got %b exp 0", tag, valid_w[k]); else pass_cnt++;
  endtask

  task automatic run_req(input int k, input string tag);
    logic [31:0] l0;
    int ex, ey, ed, c;
    bit eexh;
    c = 0;
    while (busy_w[k] !== 1'b0 && c < 300) begin @(negedge clk); c++; end
    if (c >= 300) begin chk_cnt++; $display("FAIL %s idle_wait: got busy exp idle", tag); end
    l0 = m_lfsr; req = 1'b1;
    predict(l0, k, ex, ey, eexh, ed);
    @(negedge clk);
    req = 1'b0;
    wait_valid(k, ed, ex, ey, eexh, tag);
  endtask

  task automatic test_reset;
    logic [31:0] e;
    reset = 1'b0; clk_en = 1'b1; load = 1'b0; req = 1'b0; seed = '0;
    avoid_en = 1'b0; avoid_x = '0; avoid_y = '0;
    repeat (2) @(negedge clk);
    chk_cnt++; if (busy_w[0] !== 1'b0) $display("FAIL reset busy: got %b exp 0", busy_w[0]); else pass_cnt++;
    chk_cnt++; if (valid_w[0] !== 1'b0) $display("FAIL reset valid: got %b exp 0", valid_w[0]); else pass_cnt++;
    chk_cnt++; if (exh_w[0] !== 1'b0) $display("FAIL reset exhausted: got %b exp 0", exh_w[0]); else pass_cnt++;
    chk_cnt++; if ({rx_w[0], ry_w[0]} !== 12'h0) $display("FAIL reset xy: got %0d,%0d exp 0,0", rx_w[0], ry_w[0]); else pass_cnt++;
    chk_cnt++; if (st_w[0] !== S_IDLE) $display("FAIL reset state: got %0d exp %0d", st_w[0], S_IDLE); else pass_cnt++;
    chk_cnt++; if (lf_w[0] !== 32'h0) $display("FAIL reset lfsr: got %h exp 0", lf_w[0]); else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    chk_cnt++; if (lf_w[0] !== 32'h1) $display("FAIL lfsr_first: got %h exp 1", lf_w[0]); else pass_cnt++;
    e = 32'h1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = step(e);
      chk_cnt++; if (lf_w[0] !== e) $display("FAIL lfsr_step: got %h exp %h", lf_w[0], e); else pass_cnt++;
    end
  endtask

  task automatic test_seed;
    load_seed(32'hFFFF_FFFF);
    chk_cnt++; if (lf_w[0] !== 32'h0) $display("FAIL lockup_lfsr: got %h exp 0", lf_w[0]); else pass_cnt++;
    run_req(0, "lockup_req");
    load_seed(32'h1234_5678);
    chk_cnt++; if (lf_w[0] !== 32'h1234_5678) $display("FAIL seed_lfsr: got %h exp 12345678", lf_w[0]); else pass_cnt++;
    run_req(0, "seed_req");
  endtask

  task automatic test_exhaust;
    logic [31:0] s;
    avoid_en = 1'b1; avoid_x = 6'd0; avoid_y = 6'd0;
    s = 32'hFFFF_FFFF;
    while ((&s) || step(s)[5:0] < 6'd2) s = $urandom;
    load_seed(s);
    run_req(3, "exhaust");
    chk_cnt++; if ({exh_w[3], rx_w[3], ry_w[3]} !== {1'b1, 6'd1, 6'd0})
      $display("FAIL exhaust_fixed: got %b,%0d,%0d exp 1,1,0", exh_w[3], rx_w[3], ry_w[3]); else pass_cnt++;
  endtask

  task automatic test_exclusion;
    avoid_en = 1'b1; avoid_x = 6'd0; avoid_y = 6'd0;
    load_seed($urandom);
    for (int i = 0; i < 100; i++) begin
      run_req(2, "exclusion");
      chk_cnt++; if ({rx_w[2], ry_w[2]} !== {6'd1, 6'd0})
        $display("FAIL exclusion_cell: got %0d,%0d exp 1,0", rx_w[2], ry_w[2]); else pass_cnt++;
    end
  endtask

  task automatic test_avoid_random;
    load_seed($urandom);
    for (int i = 0; i < 40; i++) begin
      avoid_en = 1'b1;
      avoid_x = 6'($urandom_range(0, (i % 8 == 7) ? 63 : 39));
      avoid_y = 6'($urandom_range(0, 19));
      run_req(0, "avoid_rand");
      chk_cnt++; if (!exh_w[0] && rx_w[0] == avoid_x && ry_w[0] == avoid_y)
        $display("FAIL avoid_hit: got %0d,%0d exp not %0d,%0d", rx_w[0], ry_w[0], avoid_x, avoid_y); else pass_cnt++;
    end
    avoid_en = 1'b0;
  endtask

  function automatic logic [31:0] good_seed(input int k);
    logic [31:0] s;
    int px, py, ed;
    bit pexh;
    do begin
      s = $urandom;
      predict(s, k, px, py, pexh, ed);
    end while ((&s) || pexh);
    return s;
  endfunction

  task automatic test_freeze;
    logic [31:0] l0;
    logic [53:0] snap;
    int ex, ey, ed, c;
    bit eexh;
    avoid_en = 1'b0;
    load_seed(good_seed(0));
    l0 = m_lfsr; req = 1'b1;
    predict(l0, 0, ex, ey, eexh, ed);
    @(negedge clk);
    req = 1'b0; c = 0;
    while (st_w[0] !== S_DRAW_Y && c < 100) begin @(negedge clk); c++; end
    chk_cnt++; if (st_w[0] !== S_DRAW_Y) $display("FAIL freeze_reach: got %0d exp %0d", st_w[0], S_DRAW_Y); else pass_cnt++;
    snap = {lf_w[0], st_w[0], busy_w[0], valid_w[0], exh_w[0], rx_w[0], ry_w[0]};
    clk_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_cnt++; if ({lf_w[0], st_w[0], busy_w[0], valid_w[0], exh_w[0], rx_w[0], ry_w[0]} !== snap)
        $display("FAIL freeze_hold: got %h exp %h", {lf_w[0], st_w[0], busy_w[0], valid_w[0], exh_w[0], rx_w[0], ry_w[0]}, snap);
      else pass_cnt++;
    end
    clk_en = 1'b1;
    while (valid_w[0] !== 1'b1 && c < 300) begin @(negedge clk); c++; end
    chk_cnt++; if (c != ed) $display("FAIL freeze_latency: got %0d exp %0d", c, ed); else pass_cnt++;
    chk_cnt++; if ({rx_w[0], ry_w[0], exh_w[0]} !== {6'(ex), 6'(ey), eexh})
      $display("FAIL freeze_result: got %0d,%0d,%b exp %0d,%0d,%b", rx_w[0], ry_w[0], exh_w[0], ex, ey, eexh); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_abort;
    logic [31:0] s2;
    int c, vcount;
    avoid_en = 1'b0;
    load_seed(good_seed(0));
    req = 1'b1;
    @(negedge clk);
    req = 1'b0; c = 0;
    while (st_w[0] !== S_CHECK && c < 100) begin @(negedge clk); c++; end
    chk_cnt++; if (st_w[0] !== S_CHECK) $display("FAIL abort_reach: got %0d exp %0d", st_w[0], S_CHECK); else pass_cnt++;
    s2 = $urandom & 32'h7FFF_FFFF;
    load_seed(s2);
    chk_cnt++; if (busy_w[0] !== 1'b0) $display("FAIL abort_busy: got %b exp 0", busy_w[0]); else pass_cnt++;
    chk_cnt++; if (valid_w[0] !== 1'b0) $display("FAIL abort_valid: got %b exp 0", valid_w[0]); else pass_cnt++;
    chk_cnt++; if (lf_w[0] !== s2) $display("FAIL abort_lfsr: got %h exp %h", lf_w[0], s2); else pass_cnt++;
    vcount = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (valid_w[0] === 1'b1) vcount++; end
    chk_cnt++; if (vcount != 0) $display("FAIL abort_no_valid: got %0d pulses exp 0", vcount); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] l0;
    int ex, ey, ed;
    bit eexh;
    avoid_en = 1'b0;
    load_seed(good_seed(0));
    req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      l0 = m_lfsr;
      predict(l0, 0, ex, ey, eexh, ed);
      @(negedge clk);
      wait_valid(0, ed, ex, ey, eexh, "back_to_back");
    end
    req = 1'b0;
  endtask

  task automatic test_range;
    bit hit_x[40], hit_y[20];
    int miss;
    avoid_en = 1'b0;
    foreach (hit_x[i]) hit_x[i] = 0;
    foreach (hit_y[i]) hit_y[i] = 0;
    load_seed($urandom & 32'h7FFF_FFFF);
    for (int i = 0; i < 2000; i++) begin
      run_req(1, "range");
      chk_cnt++; if (rx_w[1] > 6'd39 || ry_w[1] > 6'd19 || exh_w[1] !== 1'b0)
        $display("FAIL range_bounds: got %0d,%0d,%b exp <=39,<=19,0", rx_w[1], ry_w[1], exh_w[1]);
      else begin pass_cnt++; hit_x[rx_w[1]] = 1; hit_y[ry_w[1]] = 1; end
    end
    miss = 0;
    foreach (hit_x[i]) if (!hit_x[i]) miss++;
    foreach (hit_y[i]) if (!hit_y[i]) miss++;
    chk_cnt++; if (miss != 0) $display("FAIL range_coverage: got %0d values unhit exp 0", miss); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_seed();
    test_exhaust();
    test_exclusion();
    test_avoid_random();
    test_freeze();
    test_abort();
    test_back_to_back();
    test_range();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
